// File: rtl/voice_sched_pkg.sv
// Shared types and helpers for the voice phase scheduler slice.
// Build option: VOICE_HARD_SYNC_EN (hard-sync) is handled in the files that use it.
package voice_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sched_state_t;

  // A single-voice build still needs a one-bit index to keep port widths legal
  function automatic int voice_idx_width(input int num_voices);
    return (num_voices > 1) ? $clog2(num_voices) : 1;
  endfunction

endpackage

// File: rtl/voice_phase_scheduler_if.sv
// Bus between the pattern sequencer (master) and the voice phase scheduler (slave).
// VOICE_HARD_SYNC_EN adds the per-voice sync_mask input.
interface voice_phase_scheduler_if
  import voice_sched_pkg::*;
#(
  parameter int PHASE_WIDTH = 10,
  parameter int NUM_VOICES  = 4
);

  localparam int IW = voice_idx_width(NUM_VOICES);

  logic                   sample_tick;
  logic                   cfg_we;
  logic [IW-1:0]          cfg_voice;
  logic [PHASE_WIDTH-1:0] cfg_fcw;
  logic                   cfg_enable;
  logic                   cfg_phase_rst;
  logic                   overrun_clr;
`ifdef VOICE_HARD_SYNC_EN
  logic [NUM_VOICES-1:0]  sync_mask;
`endif
  logic [PHASE_WIDTH-1:0] phase_out;
  logic [IW-1:0]          voice_id;
  logic                   phase_valid;
  logic                   frame_done;
  logic                   busy;
  logic                   overrun;

  modport master (
`ifdef VOICE_HARD_SYNC_EN
    output sync_mask,
`endif
    output sample_tick, cfg_we, cfg_voice, cfg_fcw, cfg_enable, cfg_phase_rst, overrun_clr,
    input  phase_out, voice_id, phase_valid, frame_done, busy, overrun
  );

  modport slave (
`ifdef VOICE_HARD_SYNC_EN
    input  sync_mask,
`endif
    input  sample_tick, cfg_we, cfg_voice, cfg_fcw, cfg_enable, cfg_phase_rst, overrun_clr,
    output phase_out, voice_id, phase_valid, frame_done, busy, overrun
  );

endinterface

// File: rtl/voice_cfg_regfile.sv
// Per-voice FCW / enable / phase storage with a config write port and a scheduler
// read-modify-write port; a phase-reset write beats the same-cycle accumulate.
module voice_cfg_regfile
  import voice_sched_pkg::*;
#(
  parameter int  PHASE_WIDTH = 10,
  parameter int  NUM_VOICES  = 4,
  localparam int IW          = voice_idx_width(NUM_VOICES)
) (
  input  logic                   clk,
  input  logic                   rst_active_high,
  input  logic                   cfg_we,
  input  logic [IW-1:0]          cfg_voice,
  input  logic [PHASE_WIDTH-1:0] cfg_fcw,
  input  logic                   cfg_enable,
  input  logic                   cfg_phase_rst,
  input  logic [IW-1:0]          rd_idx,
  output logic [PHASE_WIDTH-1:0] rd_fcw,
  output logic                   rd_enable,
  output logic [PHASE_WIDTH-1:0] rd_phase,
  input  logic                   upd_we,
  input  logic [PHASE_WIDTH-1:0] upd_phase
);

  localparam logic [IW:0] NV_EXT = (IW+1)'(NUM_VOICES);

  logic [PHASE_WIDTH-1:0] fcw_q   [NUM_VOICES];
  logic                   en_q    [NUM_VOICES];
  logic [PHASE_WIDTH-1:0] phase_q [NUM_VOICES];
  logic                   cfg_hit;

  assign cfg_hit = cfg_we && ({1'b0, cfg_voice} < NV_EXT);

  // Reads are combinational so a same-cycle write only affects the next frame
  assign rd_fcw    = fcw_q[rd_idx];
  assign rd_enable = en_q[rd_idx];
  assign rd_phase  = phase_q[rd_idx];

  always_ff @(posedge clk or posedge rst_active_high) begin
    if (rst_active_high) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        fcw_q[v] <= '0;
        en_q[v]  <= 1'b0;
      end
    end else if (cfg_hit) begin
      fcw_q[cfg_voice] <= cfg_fcw;
      en_q[cfg_voice]  <= cfg_enable;
    end
  end

  always_ff @(posedge clk or posedge rst_active_high) begin
    if (rst_active_high) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        phase_q[v] <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (cfg_hit && cfg_phase_rst && (cfg_voice == IW'(v))) begin
          phase_q[v] <= '0;
        end else if (upd_we && (rd_idx == IW'(v))) begin
          phase_q[v] <= upd_phase;
        end
      end
    end
  end

endmodule

// File: rtl/voice_phase_scheduler.sv
// Time-multiplexed phase accumulator: one voice per clk after each sample_tick.
// Define VOICE_HARD_SYNC_EN to enable carry-driven hard sync between adjacent voices.
module voice_phase_scheduler
  import voice_sched_pkg::*;
#(
  parameter int PHASE_WIDTH = 10,
  parameter int NUM_VOICES  = 4
) (
  input  logic                  clk,
  input  logic                  rst_active_high,
  voice_phase_scheduler_if.slave bus
);

  localparam int            IW   = voice_idx_width(NUM_VOICES);
  localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);

  sched_state_t           state_q;
  sched_state_t           state_d;
  logic [IW-1:0]          idx_q;

  logic [PHASE_WIDTH-1:0] rd_fcw;
  logic                   rd_enable;
  logic [PHASE_WIDTH-1:0] rd_phase;
  logic                   upd_we;
  logic [PHASE_WIDTH-1:0] sum;
  logic [PHASE_WIDTH-1:0] new_phase;

  logic [PHASE_WIDTH-1:0] phase_out_q;
  logic [IW-1:0]          voice_id_q;
  logic                   phase_valid_q;
  logic                   frame_done_q;
  logic                   busy_q;
  logic                   overrun_q;

`ifdef VOICE_HARD_SYNC_EN
  logic carry;
  logic carry_out;
  logic sync_pend_q;

  assign {carry, sum} = {1'b0, rd_phase} + {1'b0, rd_fcw};
`else
  assign sum = rd_phase + rd_fcw;
`endif

  voice_cfg_regfile #(
    .PHASE_WIDTH (PHASE_WIDTH),
    .NUM_VOICES  (NUM_VOICES)
  ) u_regfile (
    .clk             (clk),
    .rst_active_high (rst_active_high),
    .cfg_we          (bus.cfg_we),
    .cfg_voice       (bus.cfg_voice),
    .cfg_fcw         (bus.cfg_fcw),
    .cfg_enable      (bus.cfg_enable),
    .cfg_phase_rst   (bus.cfg_phase_rst),
    .rd_idx          (idx_q),
    .rd_fcw          (rd_fcw),
    .rd_enable       (rd_enable),
    .rd_phase        (rd_phase),
    .upd_we          (upd_we),
    .upd_phase       (new_phase)
  );

  always_ff @(posedge clk or posedge rst_active_high) begin
    if (rst_active_high) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == RUN && idx_q != LAST) begin
        idx_q <= idx_q + IW'(1);
      end else begin
        idx_q <= '0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.sample_tick) state_d = RUN;
      RUN:     if (idx_q == LAST)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A disabled voice is still written back (with its held phase) and reported
  always_comb begin
    upd_we    = (state_q == RUN);
    new_phase = rd_phase;
`ifdef VOICE_HARD_SYNC_EN
    carry_out = 1'b0;
`endif
    if (state_q == RUN && rd_enable) begin
      new_phase = sum;
`ifdef VOICE_HARD_SYNC_EN
      carry_out = carry;
`endif
    end
`ifdef VOICE_HARD_SYNC_EN
    if (state_q == RUN && sync_pend_q && idx_q != '0 && bus.sync_mask[idx_q]) begin
      new_phase = '0;
      carry_out = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst_active_high) begin
    if (rst_active_high) begin
      phase_out_q   <= '0;
      voice_id_q    <= '0;
      phase_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      phase_valid_q <= (state_q == RUN);
      frame_done_q  <= (state_q == RUN) && (idx_q == LAST);
      busy_q        <= (state_d == RUN);
      if (state_q == RUN) begin
        phase_out_q <= new_phase;
        voice_id_q  <= idx_q;
      end
      // A dropped tick must win over a same-cycle clear
      if (bus.sample_tick && state_q == RUN) begin
        overrun_q <= 1'b1;
      end else if (bus.overrun_clr) begin
        overrun_q <= 1'b0;
      end
    end
  end

`ifdef VOICE_HARD_SYNC_EN
  // The carry only links neighbours within one frame, never last voice to voice 0
  always_ff @(posedge clk or posedge rst_active_high) begin
    if (rst_active_high) begin
      sync_pend_q <= 1'b0;
    end else begin
      sync_pend_q <= (state_q == RUN && idx_q != LAST) ? carry_out : 1'b0;
    end
  end
`endif

  assign bus.phase_out   = phase_out_q;
  assign bus.voice_id    = voice_id_q;
  assign bus.phase_valid = phase_valid_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.busy        = busy_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_voice_phase_scheduler.sv
// Directed self-checking bench for voice_phase_scheduler (4 voices, 10-bit phase).
// Inputs change and outputs are sampled on the falling edge.
module tb_voice_phase_scheduler;

  localparam int PW = 10;
  localparam int NV = 4;
  localparam int IW = $clog2(NV);

  logic clk = 1'b0;
  logic rst_active_high = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [IW-1:0] pendVoice;
  logic [PW-1:0] pendFcw;
  logic          pendEn;
  logic          pendPrst;

  always #5 clk = ~clk;

  voice_phase_scheduler_if #(.PHASE_WIDTH(PW), .NUM_VOICES(NV)) bus ();

  voice_phase_scheduler #(
    .PHASE_WIDTH (PW),
    .NUM_VOICES  (NV)
  ) dut (
    .clk             (clk),
    .rst_active_high (rst_active_high),
    .bus             (bus.slave)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic tick, input logic we, input logic [IW-1:0] v,
                               input logic [PW-1:0] f, input logic en, input logic prst,
                               input logic clr);
    bus.sample_tick   = tick;
    bus.cfg_we        = we;
    bus.cfg_voice     = v;
    bus.cfg_fcw       = f;
    bus.cfg_enable    = en;
    bus.cfg_phase_rst = prst;
    bus.overrun_clr   = clr;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  task automatic cfgWrite(input logic [IW-1:0] v, input logic [PW-1:0] f, input logic en, input logic prst);
    applyStimulus(1'b0, 1'b1, v, f, en, prst, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doReset(input string name);
    rst_active_high = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput({name, "_rst_valid"},   32'(bus.phase_valid), 32'd0);
    checkOutput({name, "_rst_done"},    32'(bus.frame_done),  32'd0);
    checkOutput({name, "_rst_busy"},    32'(bus.busy),        32'd0);
    checkOutput({name, "_rst_overrun"}, 32'(bus.overrun),     32'd0);
    checkOutput({name, "_rst_phase"},   32'(bus.phase_out),   32'd0);
    checkOutput({name, "_rst_id"},      32'(bus.voice_id),    32'd0);
    rst_active_high = 1'b0;
    @(negedge clk);
  endtask

  // Cycle numbering: tick sampled in cycle 0; cycleN inputs are sampled at its closing edge
  task automatic runFrame(input string name, input logic [PW-1:0] e0, input logic [PW-1:0] e1,
                          input logic [PW-1:0] e2, input logic [PW-1:0] e3, input bit sendTick,
                          input int dupCycle, input int clrCycle, input int cfgCycle);
    logic [PW-1:0] exp [NV];
    exp = '{e0, e1, e2, e3};
    if (sendTick) begin
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
    end
    for (int c = 1; c <= NV + 1; c++) begin
      checkOutput($sformatf("%s_c%0d_busy", name, c),  32'(bus.busy),        32'(c <= NV));
      checkOutput($sformatf("%s_c%0d_valid", name, c), 32'(bus.phase_valid), 32'(c >= 2));
      checkOutput($sformatf("%s_c%0d_done", name, c),  32'(bus.frame_done),  32'(c == NV + 1));
      if (c >= 2) begin
        checkOutput($sformatf("%s_c%0d_id", name, c),    32'(bus.voice_id),  32'(c - 2));
        checkOutput($sformatf("%s_c%0d_phase", name, c), 32'(bus.phase_out), 32'(exp[c-2]));
      end
      if (c == cfgCycle) begin
        applyStimulus(c == dupCycle, 1'b1, pendVoice, pendFcw, pendEn, pendPrst, c == clrCycle);
      end else begin
        applyStimulus(c == dupCycle, 1'b0, '0, '0, 1'b0, 1'b0, c == clrCycle);
      end
      @(negedge clk);
    end
    checkOutput({name, "_post_valid"}, 32'(bus.phase_valid), 32'd0);
    checkOutput({name, "_post_done"},  32'(bus.frame_done),  32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    pendVoice = '0;
    pendFcw   = '0;
    pendEn    = 1'b0;
    pendPrst  = 1'b0;
`ifdef VOICE_HARD_SYNC_EN
    bus.sync_mask = '0;
`endif
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Basic accumulation, plus a tick accepted in the last cycle of a frame
    doReset("t1");
    cfgWrite(2'd0, 10'd3, 1'b1, 1'b0);
    runFrame("t1f1", 10'd3, 10'd0, 10'd0, 10'd0, 1'b1, 0, 0, 0);
    runFrame("t1f2", 10'd6, 10'd0, 10'd0, 10'd0, 1'b1, 0, 0, 0);
    runFrame("t1f3", 10'd9, 10'd0, 10'd0, 10'd0, 1'b1, NV + 1, 0, 0);
    runFrame("t1f4", 10'd12, 10'd0, 10'd0, 10'd0, 1'b0, 0, 0, 0);
    checkOutput("t1_overrun", 32'(bus.overrun), 32'd0);

    // Modulo wrap
    doReset("t2");
    cfgWrite(2'd0, 10'd1000, 1'b1, 1'b0);
    runFrame("t2f1", 10'd1000, 10'd0, 10'd0, 10'd0, 1'b1, 0, 0, 0);
    runFrame("t2f2", 10'd976, 10'd0, 10'd0, 10'd0, 1'b1, 0, 0, 0);

    // Tick while busy, sticky overrun, clear, then set beating clear
    doReset("t3");
    cfgWrite(2'd1, 10'd10, 1'b1, 1'b0);
    runFrame("t3f1", 10'd0, 10'd10, 10'd0, 10'd0, 1'b1, 2, 0, 0);
    checkOutput("t3_overrun_set", 32'(bus.overrun), 32'd1);
    idleCycle();
    checkOutput("t3_overrun_sticky", 32'(bus.overrun), 32'd1);
    checkOutput("t3_no_extra_frame", 32'(bus.phase_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("t3_overrun_clr", 32'(bus.overrun), 32'd0);
    runFrame("t3f2", 10'd0, 10'd20, 10'd0, 10'd0, 1'b1, 2, 2, 0);
    checkOutput("t3_set_wins", 32'(bus.overrun), 32'd1);

    // Config write colliding with the voice being computed
    doReset("t4");
    cfgWrite(2'd2, 10'd1, 1'b1, 1'b0);
    pendVoice = 2'd2; pendFcw = 10'd5; pendEn = 1'b1; pendPrst = 1'b0;
    runFrame("t4f1", 10'd0, 10'd0, 10'd1, 10'd0, 1'b1, 0, 0, 3);
    runFrame("t4f2", 10'd0, 10'd0, 10'd6, 10'd0, 1'b1, 0, 0, 0);
    pendPrst = 1'b1;
    runFrame("t4f3", 10'd0, 10'd0, 10'd11, 10'd0, 1'b1, 0, 0, 3);
    runFrame("t4f4", 10'd0, 10'd0, 10'd5, 10'd0, 1'b1, 0, 0, 0);

    // Reset in the middle of a frame
    doReset("t5");
    cfgWrite(2'd0, 10'd3, 1'b1, 1'b0);
    runFrame("t5f1", 10'd3, 10'd0, 10'd0, 10'd0, 1'b1, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t5_pre_valid", 32'(bus.phase_valid), 32'd1);
    checkOutput("t5_pre_phase", 32'(bus.phase_out), 32'd6);
    rst_active_high = 1'b1;
    #1;
    checkOutput("t5_async_valid", 32'(bus.phase_valid), 32'd0);
    checkOutput("t5_async_busy",  32'(bus.busy),        32'd0);
    checkOutput("t5_async_phase", 32'(bus.phase_out),   32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("t5_hold%0d_done", i), 32'(bus.frame_done), 32'd0);
    end
    rst_active_high = 1'b0;
    @(negedge clk);
    checkOutput("t5_after_done", 32'(bus.frame_done), 32'd0);
    checkOutput("t5_after_busy", 32'(bus.busy), 32'd0);
    cfgWrite(2'd0, 10'd4, 1'b1, 1'b0);
    runFrame("t5f2", 10'd4, 10'd0, 10'd0, 10'd0, 1'b1, 0, 0, 0);

`ifdef VOICE_HARD_SYNC_EN
    // Hard sync: voice 0 wrap forces voice 1 to zero
    doReset("t6");
    bus.sync_mask = 4'b0010;
    cfgWrite(2'd0, 10'd600, 1'b1, 1'b0);
    cfgWrite(2'd1, 10'd7, 1'b1, 1'b0);
    runFrame("t6f1", 10'd600, 10'd7, 10'd0, 10'd0, 1'b1, 0, 0, 0);
    runFrame("t6f2", 10'd176, 10'd0, 10'd0, 10'd0, 1'b1, 0, 0, 0);
    runFrame("t6f3", 10'd776, 10'd7, 10'd0, 10'd0, 1'b1, 0, 0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
